gba_line_sched: RTL
===================

# gba_line_sched

Frame-lock and line-fetch scheduler for the HDMI image path. Aligns the HDMI raster to the incoming GBA frame by issuing a one-shot start-position request, tracks the vertical scale phase, and schedules line-cache advances (`nextLine`) and refreshes (`cacheUpdate`) once per output line. Sits between the HDMI timing generator (`cx`/`cy`) and the line cache, replacing ad-hoc sequencing in the image generator.

## Interface
- `SCALE`, default 5: integer scale factor, output lines per GBA line (1..8).
- `Y_START`, default 40: first output line of the GBA window.
- `GBA_LINES`, default 160: GBA lines per frame.
- `FETCH_LEAD`, default 8: fetch point, in pixels before the end of the line.
- `LOCK_TIMEOUT`, default 3: frames without `newFrameIn` before lock is dropped.

Ports (reset `rst`, synchronous, active-high; clock `pxlClk`):
- `pxlClk`  in  1  pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `cx`  in  12  HDMI current x.
- `cy`  in  11  HDMI current y.
- `frameWidth`  in  12  total line length.
- `frameHeight`  in  11  total frame height.
- `newFrameIn`  in  1  GBA frame-start level; rising edge marks a new frame.
- `sameLine`  in  1  capture side has not finished the next line; blocks advance.
- `setStart`  out  1  HDMI start-position load request.
- `setStartX`  out  12  start x, always 0.
- `setStartY`  out  11  start y, `Y_START-2`.
- `nextLine`  out  1  one-cycle advance pulse to the line cache.
- `cacheUpdate`  out  1  one-cycle refresh pulse.
- `lineCntScale`  out  3  vertical phase, 0..SCALE-1.
- `gbaLine`  out  8  GBA line currently shown, 0..GBA_LINES-1.
- `locked`  out  1  raster aligned to the GBA frame.

## Operation
- FSM states are IDLE, SYNC, RUN and BLANK.
- **IDLE**: `locked`=0. A `newFrameIn` rising edge moves to SYNC.
- **SYNC**: `setStart`=1, with `setStartX`=0 and `setStartY`=`Y_START-2`.
  - Hold until `cy` changes from its value one cycle earlier.
  - Then `setStart`=0, `locked`=1, `lineCntScale`=0, `gbaLine`=0, and go to RUN.
- **RUN**: the fetch point is `cx == frameWidth-FETCH_LEAD`.
  - At the fetch point: pulse `cacheUpdate`.
  - Also pulse `nextLine` when all of these hold: `cy>=Y_START`, `lineCntScale==SCALE-1`, `sameLine`=0.
  - At `cx == frameWidth-1` with `cy>=Y_START`: increment `lineCntScale`, wrapping SCALE-1 to 0.
  - On that wrap, `gbaLine` increments, unless the fetch point of the same line was blocked by `sameLine`; then `gbaLine` holds (line repeat).
  - When `gbaLine` wraps from `GBA_LINES-1`, go to BLANK.
- **BLANK**: no `nextLine`; `cacheUpdate` continues.
  - A `newFrameIn` rising edge moves to SYNC.
  - A frame counter increments at `cy==frameHeight-1`, `cx==frameWidth-1`. When it reaches `LOCK_TIMEOUT`: `locked`=0, go to IDLE.
- **Resync**: a `newFrameIn` rising edge in RUN goes to SYNC immediately; the fresh edge wins.
- **`cy` wrap**: at `cy==frameHeight-1`, `cx==frameWidth-1`, `lineCntScale` clears to 0.
- **Reset**, including mid-operation: state IDLE, all counters 0, every output 0 (including `setStartY`). `setStartX`/`setStartY` are loaded only on entering SYNC.

## Timing
- All outputs are registered: one-cycle latency from the `cx`/`cy`/`newFrameIn` sample that triggers them.
- `newFrameIn` edge detection uses one internal delay register. SYNC is entered 2 cycles after the rising level appears.
- `nextLine` and `cacheUpdate` are exactly one cycle wide, at most once per output line.
- `setStart` asserts for at least 1 cycle and deasserts the cycle after the `cy` change is detected.
- Widths are as declared. Compares are unsigned. `frameWidth-FETCH_LEAD` is computed at 12 bits.

## Configuration
- `SCHED_STATS_EN` defined: adds the following outputs, all cleared by reset and saturating at all-ones.
  - `stallCount` (16 bits): fetch points blocked by `sameLine`.
  - `resyncCount` (8 bits): RUN-to-SYNC transitions.
- `SCHED_STATS_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- The state enum `sched_state_t` and the `FETCH_LEAD` default belong in `definePackage`.
- One sub-module, `sched_line_counter`:
  - holds the `lineCntScale`/`gbaLine` pair;
  - inputs: advance, block and clear;
  - output: a wrap flag.
- The FSM, edge detect and timeout remain in the top level.

## Test plan
- **Lock**: SCALE=5, Y_START=40, frameWidth=1650, frameHeight=750; raise `newFrameIn` -> `setStart`=1 with `setStartY`=38 until `cy` steps; then `locked`=1 and state RUN.
- **Fetch cadence**: `sameLine`=0 for a full frame -> `cacheUpdate` at `cx`=1642 every line; `nextLine` every 5th line from `cy`=44; 160 `nextLine` pulses total; then BLANK.
- **Stall**: `sameLine`=1 at one fetch point with `lineCntScale`=4 -> no `nextLine`; `gbaLine` repeats; `stallCount`=1 with `SCHED_STATS_EN`.
- **Resync**: `newFrameIn` rising edge mid-RUN at `gbaLine`=70 -> SYNC within 2 cycles; `gbaLine`=0 after the `cy` step; `resyncCount`=1.
- **Timeout**: no `newFrameIn` for 3 frames in BLANK -> `locked`=0, IDLE; no `nextLine` pulses.
- **Reset**: `rst` mid-RUN for 1 cycle -> all outputs 0 the next cycle; relock on the next edge.

Source files
------------

// File: rtl/gba_line_sched_pkg.sv
// Shared types and defaults for the GBA line scheduler.
// Holds the scheduler state encoding and saturating-count helpers.
package definePackage;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN,
        ST_BLANK
    } sched_state_t;

    localparam int FETCH_LEAD_DEF   = 8;
    localparam int LOCK_TIMEOUT_DEF = 3;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gba_line_sched_line_counter.sv
// Vertical scale phase and GBA line counter pair.
// Wrap flag reports the last GBA line rolling over to 0.
module sched_line_counter
    import definePackage::*;
#(
    parameter int SCALE     = 5,
    parameter int GBA_LINES = 160
) (
    input  logic       pxlClk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic       block_i,
    input  logic       phaseClr_i,
    output logic [2:0] lineCntScale_o,
    output logic [7:0] gbaLine_o,
    output logic       wrap_o
);

    logic [2:0] phase_q, phase_d;
    logic [7:0] line_q, line_d;
    logic       lastPhase;
    logic       lastLine;

    assign lastPhase      = phase_q == 3'(SCALE - 1);
    assign lastLine       = line_q == 8'(GBA_LINES - 1);
    assign wrap_o         = !clear_i && advance_i && lastPhase
                            && !block_i && lastLine;
    assign lineCntScale_o = phase_q;
    assign gbaLine_o      = line_q;

    // Next phase/line: a blocked fetch repeats the GBA line.
    always_comb begin
        phase_d = phase_q;
        line_d  = line_q;
        if (clear_i) begin
            phase_d = '0;
            line_d  = '0;
        end else begin
            if (advance_i) begin
                if (lastPhase) begin
                    phase_d = '0;
                    if (!block_i)
                        line_d = lastLine ? 8'd0 : line_q + 8'd1;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            if (phaseClr_i)
                phase_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            phase_q <= '0;
            line_q  <= '0;
        end else begin
            phase_q <= phase_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/gba_line_sched.sv
// Frame-lock and line-fetch scheduler for the HDMI image path.
// Define SCHED_STATS_EN to add stallCount/resyncCount outputs.
module gba_line_sched
    import definePackage::*;
#(
    parameter int SCALE        = 5,
    parameter int Y_START      = 40,
    parameter int GBA_LINES    = 160,
    parameter int FETCH_LEAD   = FETCH_LEAD_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic        pxlClk,
    input  logic        rst,
    input  logic [11:0] cx,
    input  logic [10:0] cy,
    input  logic [11:0] frameWidth,
    input  logic [10:0] frameHeight,
    input  logic        newFrameIn,
    input  logic        sameLine,
    output logic        setStart,
    output logic [11:0] setStartX,
    output logic [10:0] setStartY,
    output logic        nextLine,
    output logic        cacheUpdate,
    output logic [2:0]  lineCntScale,
    output logic [7:0]  gbaLine,
    output logic        locked
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] stallCount,
    output logic [7:0]  resyncCount
`endif
);

    localparam logic [10:0] START_Y  = 11'(Y_START - 2);
    localparam logic [7:0]  FRM_LAST = 8'(LOCK_TIMEOUT - 1);

    sched_state_t state_q;
    logic        nfs_q, nf_q;
    logic [10:0] cy_q;
    logic        blk_q;
    logic        setStart_q, locked_q;
    logic [11:0] setStartX_q;
    logic [10:0] setStartY_q;
    logic        nextLine_q, cacheUpdate_q;
    logic [7:0]  frm_q;

    logic rise, cyStep, fetch, eol, eof, inWin, lastPh;
    logic blockNow, runLive, lineWrap;

    assign rise     = nfs_q && !nf_q;
    assign cyStep   = cy != cy_q;
    assign fetch    = cx == (frameWidth - 12'(FETCH_LEAD));
    assign eol      = cx == (frameWidth - 12'd1);
    assign eof      = eol && (cy == (frameHeight - 11'd1));
    assign inWin    = cy >= 11'(Y_START);
    assign lastPh   = lineCntScale == 3'(SCALE - 1);
    assign runLive  = (state_q == ST_RUN) && !rise;
    assign blockNow = runLive && fetch && inWin && lastPh && sameLine;

    assign setStart    = setStart_q;
    assign setStartX   = setStartX_q;
    assign setStartY   = setStartY_q;
    assign nextLine    = nextLine_q;
    assign cacheUpdate = cacheUpdate_q;
    assign locked      = locked_q;

    sched_line_counter #(
        .SCALE     (SCALE),
        .GBA_LINES (GBA_LINES)
    ) u_cnt (
        .pxlClk         (pxlClk),
        .rst            (rst),
        .clear_i        ((state_q == ST_SYNC) && cyStep),
        .advance_i      (runLive && eol && inWin),
        .block_i        (blk_q || blockNow),
        .phaseClr_i     (eof),
        .lineCntScale_o (lineCntScale),
        .gbaLine_o      (gbaLine),
        .wrap_o         (lineWrap)
    );

    // Input sample, frame-edge delay and previous-line capture.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            nfs_q <= 1'b0;
            nf_q  <= 1'b0;
            cy_q  <= '0;
        end else begin
            nfs_q <= newFrameIn;
            nf_q  <= nfs_q;
            cy_q  <= cy;
        end
    end

    // Remember a blocked fetch until the end of its line.
    always_ff @(posedge pxlClk) begin
        if (rst)
            blk_q <= 1'b0;
        else if (blockNow)
            blk_q <= 1'b1;
        else if (eol)
            blk_q <= 1'b0;
    end

    // Lock FSM with registered outputs and blank-frame timeout.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            setStart_q    <= 1'b0;
            setStartX_q   <= '0;
            setStartY_q   <= '0;
            locked_q      <= 1'b0;
            nextLine_q    <= 1'b0;
            cacheUpdate_q <= 1'b0;
            frm_q         <= '0;
        end else begin
            nextLine_q    <= 1'b0;
            cacheUpdate_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q     <= ST_SYNC;
                        setStart_q  <= 1'b1;
                        setStartX_q <= '0;
                        setStartY_q <= START_Y;
                    end
                end
                ST_SYNC: begin
                    if (cyStep) begin
                        setStart_q <= 1'b0;
                        locked_q   <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rise) begin
                        state_q     <= ST_SYNC;
                        setStart_q  <= 1'b1;
                        setStartX_q <= '0;
                        setStartY_q <= START_Y;
                    end else begin
                        cacheUpdate_q <= fetch;
                        nextLine_q    <= fetch && inWin && lastPh
                                         && !sameLine;
                        if (lineWrap) begin
                            state_q <= ST_BLANK;
                            frm_q   <= '0;
                        end
                    end
                end
                ST_BLANK: begin
                    if (rise) begin
                        state_q     <= ST_SYNC;
                        setStart_q  <= 1'b1;
                        setStartX_q <= '0;
                        setStartY_q <= START_Y;
                    end else begin
                        cacheUpdate_q <= fetch;
                        if (eof) begin
                            if (frm_q == FRM_LAST) begin
                                locked_q <= 1'b0;
                                state_q  <= ST_IDLE;
                                frm_q    <= '0;
                            end else begin
                                frm_q <= frm_q + 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] stall_q;
    logic [7:0]  resync_q;

    assign stallCount  = stall_q;
    assign resyncCount = resync_q;

    // Saturating stall and resync statistics.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            stall_q  <= '0;
            resync_q <= '0;
        end else begin
            if (blockNow)
                stall_q <= satInc16(stall_q);
            if ((state_q == ST_RUN) && rise)
                resync_q <= satInc8(resync_q);
        end
    end
`endif

endmodule
